regfile_scoreboard: RTL

- Parametrised successor to the core's integer register file.
- Two combinational read ports, one synchronous write port, and x0 hardwired to zero.
- Adds a per-register busy scoreboard so the decode stage can stall on in-flight destinations.
- Adds a configurable LED debug tap.
- Sits between decode (reads, issue marking) and writeback (register write, busy clear).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 44 ++++
 rtl/regfile_scoreboard.sv | 81 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded integer register file.
package regfile_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = $clog2(NREGS_DEF);
  localparam int REG_ZERO   = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: stored data and busy bit, with optional write-through
// forwarding from writeback when REGFILE_BYPASS_EN is defined. Zero latency, no backpressure.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic [ADDR_W-1:0]           addr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  input  logic                        iss_en,
  input  logic [ADDR_W-1:0]           iss_addr,
  output logic [XLEN-1:0]             rd_data,
  output logic                        rd_busy
);

`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  // Entry 0 of regs/busy is tied to zero by the owner, so x0 needs no special case here.
  always_comb begin
    rd_data = regs[addr];
    rd_busy = busy[addr];
    if (wr_en && (wr_addr != ZERO) && (wr_addr == addr)) begin
      rd_data = wr_data;
      rd_busy = iss_en && (iss_addr == addr);
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data, iss_en, iss_addr};

  always_comb begin
    rd_data = regs[addr];
    rd_busy = busy[addr];
  end
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file (2 comb reads, 1 sync write, x0 = 0) with per-register busy scoreboard and LED tap.
// Writes visible next cycle, or same cycle with REGFILE_BYPASS_EN; no backpressure (decode stalls on busy).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int ADDR_W  = $clog2(NREGS),
  parameter int LED_REG = 1,
  parameter int LED_W   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]   data,
  input  logic              reg_write,
  output logic [LED_W-1:0]  led
);

  logic [NREGS-1:1][XLEN-1:0] regs_q;
  logic [NREGS-1:1]           busy_q;
  logic [NREGS-1:0][XLEN-1:0] regs_all;
  logic [NREGS-1:0]           busy_all;

  assign regs_all = {regs_q, {XLEN{1'b0}}};
  assign busy_all = {busy_q, 1'b0};

  // A new producer issued in the same cycle supersedes the one retiring.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (reg_write && (rd == ADDR_W'(r)))
          regs_q[r] <= data;
        if (issue_valid && (issue_rd == ADDR_W'(r)))
          busy_q[r] <= 1'b1;
        else if (reg_write && (rd == ADDR_W'(r)))
          busy_q[r] <= 1'b0;
      end
    end
  end

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_port1 (
    .addr     (rs1),
    .regs     (regs_all),
    .busy     (busy_all),
    .wr_en    (reg_write),
    .wr_addr  (rd),
    .wr_data  (data),
    .iss_en   (issue_valid),
    .iss_addr (issue_rd),
    .rd_data  (rs1_data),
    .rd_busy  (rs1_busy)
  );

  regfile_read_port #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_port2 (
    .addr     (rs2),
    .regs     (regs_all),
    .busy     (busy_all),
    .wr_en    (reg_write),
    .wr_addr  (rd),
    .wr_data  (data),
    .iss_en   (issue_valid),
    .iss_addr (issue_rd),
    .rd_data  (rs2_data),
    .rd_busy  (rs2_busy)
  );

  assign led = ~regs_all[LED_REG][LED_W-1:0];

endmodule
